// File: rtl/fault_manager_multich.sv
// Multi-channel fault manager for the step-down converter power stages.
// Each channel has a detect synchroniser with debounce, a leaky-bucket
// current-limit counter, and an OFF/RUN/HICCUP/LATCHED fault FSM with a
// bounded hiccup auto-retry. tmi[4:0] selects test modes.
module fault_manager_multich #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned DEB_CNT   = 8,
  parameter int unsigned ILIM_MAX  = 32,
  parameter int unsigned RETRY_CYC = 512,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             CLK_FAULT,
  input  logic             PORB97836,
  input  logic [NCH-1:0]   enable_fault,
  input  logic [NCH-1:0]   detect,
  input  logic [NCH-1:0]   current_limit,
  input  logic             hiccup_en,
  input  logic             clear_fault,
  input  logic [4:0]       tmi,
  output logic [NCH-1:0]   enable,
  output logic [NCH-1:0]   ok_fault,
  output logic [NCH-1:0]   fault_short,
  output logic [2*NCH-1:0] fault_cause,
  output logic             fault_any
);

  localparam int unsigned DW = $clog2(DEB_CNT + 1);
  localparam int unsigned BW = $clog2(ILIM_MAX + 1);
  localparam int unsigned TW = $clog2(RETRY_CYC + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CNT);
  localparam logic [BW-1:0] BKT_MAX = BW'(ILIM_MAX);
  localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRY);

  localparam logic [4:0] TMI_FORCE   = 5'b10001;
  localparam logic [4:0] TMI_NODEB   = 5'b10010;
  localparam logic [4:0] TMI_FASTRTY = 5'b10011;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RUN     = 2'd1,
    ST_HICCUP  = 2'd2,
    ST_LATCHED = 2'd3
  } state_e;

  state_e                 state_q [NCH];
  state_e                 state_d [NCH];
  logic [NCH-1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NCH-1:0][DW-1:0] deb_q, deb_d;
  logic [NCH-1:0][BW-1:0] bkt_q, bkt_d, bkt_nxt;
  logic [NCH-1:0][TW-1:0] tmr_q, tmr_d;
  logic [NCH-1:0][RW-1:0] rty_q, rty_d;
  logic [NCH-1:0][1:0]    cause_q, cause_d;
  logic [NCH-1:0]         enable_q, enable_d, ok_q, ok_d, fs_q, fs_d;
  logic                   fault_any_q, fault_any_d;
  logic [NCH-1:0]         short_trip, ilim_trip, run_stay;
  logic                   force_trip;
  logic [DW-1:0]          deb_lim;
  logic [TW-1:0]          tmr_last;

  // Test-mode decode: applies to the very next edge, limits compared with >=
  always_comb begin
    force_trip = (tmi == TMI_FORCE);
    deb_lim    = (tmi == TMI_NODEB) ? DW'(1) : DEB_MAX;
    tmr_last   = (tmi == TMI_FASTRTY) ? TW'(15) : TW'(RETRY_CYC - 1);
  end

  // Trip conditions: short uses the registered debounce count (one edge of
  // latency), current limit uses the bucket value being written this edge
  always_comb begin
    bkt_nxt    = '0;
    short_trip = '0;
    ilim_trip  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (current_limit[i]) begin
        bkt_nxt[i] = (bkt_q[i] == BKT_MAX) ? bkt_q[i] : bkt_q[i] + BW'(1);
      end else begin
        bkt_nxt[i] = (bkt_q[i] == '0) ? '0 : bkt_q[i] - BW'(1);
      end
      short_trip[i] = (deb_q[i] >= deb_lim) || force_trip;
      ilim_trip[i]  = (bkt_nxt[i] >= BKT_MAX);
    end
  end

  // Next-state logic per channel; enable_fault=0 overrides everything
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_OFF:     if (enable_fault[i]) state_d[i] = ST_RUN;
        ST_RUN: begin
          if (short_trip[i] || ilim_trip[i]) begin
            if (hiccup_en && ((MAX_RETRY == 0) || (rty_q[i] < RTY_MAX))) begin
              state_d[i] = ST_HICCUP;
            end else begin
              state_d[i] = ST_LATCHED;
            end
          end
        end
        ST_HICCUP:  if (tmr_q[i] >= tmr_last) state_d[i] = ST_RUN;
        ST_LATCHED: if (clear_fault) state_d[i] = ST_OFF;
        default:    state_d[i] = ST_OFF;
      endcase
      if (!enable_fault[i]) state_d[i] = ST_OFF;
    end
  end

  // Counters and cause bits; debounce and bucket only run while staying in RUN
  always_comb begin
    sync1_d  = detect;
    sync2_d  = sync1_q;
    run_stay = '0;
    deb_d    = '0;
    bkt_d    = '0;
    tmr_d    = '0;
    rty_d    = rty_q;
    cause_d  = cause_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      run_stay[i] = (state_q[i] == ST_RUN) && (state_d[i] == ST_RUN);
      if (run_stay[i] && sync2_q[i]) begin
        deb_d[i] = (deb_q[i] == DEB_MAX) ? deb_q[i] : deb_q[i] + DW'(1);
      end
      if (run_stay[i]) bkt_d[i] = bkt_nxt[i];
      if ((state_q[i] == ST_HICCUP) && (state_d[i] == ST_HICCUP)) begin
        tmr_d[i] = tmr_q[i] + TW'(1);
      end
      if (state_d[i] == ST_OFF) begin
        rty_d[i]   = '0;
        cause_d[i] = '0;
      end else if ((state_q[i] == ST_RUN) && (state_d[i] != ST_RUN)) begin
        cause_d[i] = cause_q[i] | {ilim_trip[i], short_trip[i]};
        if ((state_d[i] == ST_HICCUP) && (MAX_RETRY != 0)) begin
          rty_d[i] = rty_q[i] + RW'(1);
        end
      end
    end
  end

  // Output decode from the next state so registered outputs align with state
  always_comb begin
    enable_d = '0;
    ok_d     = '0;
    fs_d     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      enable_d[i] = (state_d[i] == ST_RUN);
      ok_d[i]     = (state_d[i] == ST_RUN) && !sync2_d[i];
      fs_d[i]     = (state_d[i] == ST_HICCUP) || (state_d[i] == ST_LATCHED);
    end
    fault_any_d = |fs_d;
  end

  // State, counter and output registers
  always_ff @(posedge CLK_FAULT or negedge PORB97836) begin
    if (!PORB97836) begin
      for (int unsigned i = 0; i < NCH; i++) state_q[i] <= ST_OFF;
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      bkt_q       <= '0;
      tmr_q       <= '0;
      rty_q       <= '0;
      cause_q     <= '0;
      enable_q    <= '0;
      ok_q        <= '0;
      fs_q        <= '0;
      fault_any_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) state_q[i] <= state_d[i];
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      bkt_q       <= bkt_d;
      tmr_q       <= tmr_d;
      rty_q       <= rty_d;
      cause_q     <= cause_d;
      enable_q    <= enable_d;
      ok_q        <= ok_d;
      fs_q        <= fs_d;
      fault_any_q <= fault_any_d;
    end
  end

  assign enable      = enable_q;
  assign ok_fault    = ok_q;
  assign fault_short = fs_q;
  assign fault_cause = cause_q;
  assign fault_any   = fault_any_q;

endmodule

// File: tb/tb_fault_manager_multich.sv
// Self-checking bench for fault_manager_multich with a behavioural channel
// model, directed scenarios and a randomized soak.
module tb_fault_manager_multich;

  localparam int NCH       = 4;
  localparam int DEB_CNT   = 8;
  localparam int ILIM_MAX  = 32;
  localparam int RETRY_CYC = 512;
  localparam int MAX_RETRY = 3;

  localparam int M_OFF = 0;
  localparam int M_RUN = 1;
  localparam int M_HIC = 2;
  localparam int M_LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] enable_fault = '0;
  logic [3:0] detect = '0;
  logic [3:0] current_limit = '0;
  logic       hiccup_en = 1'b0;
  logic       clear_fault = 1'b0;
  logic [4:0] tmi = '0;
  logic [3:0] enable, ok_fault, fault_short;
  logic [7:0] fault_cause;
  logic       fault_any;

  int n_checks = 0;
  int n_err = 0;

  fault_manager_multich #(
    .NCH(NCH), .DEB_CNT(DEB_CNT), .ILIM_MAX(ILIM_MAX),
    .RETRY_CYC(RETRY_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .CLK_FAULT(clk), .PORB97836(rst_n), .enable_fault(enable_fault),
    .detect(detect), .current_limit(current_limit), .hiccup_en(hiccup_en),
    .clear_fault(clear_fault), .tmi(tmi), .enable(enable), .ok_fault(ok_fault),
    .fault_short(fault_short), .fault_cause(fault_cause), .fault_any(fault_any)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel state plus plain integer counters
  int       m_st [NCH];
  int       m_deb [NCH];
  int       m_bkt [NCH];
  int       m_rty [NCH];
  int       m_hstart [NCH];
  bit       m_s1 [NCH];
  bit       m_s2 [NCH];
  bit [1:0] m_cause [NCH];
  int       m_cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    int thr, off, bk, ns;
    bit sh, il;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_st[c] = M_OFF; m_deb[c] = 0; m_bkt[c] = 0; m_rty[c] = 0;
        m_hstart[c] = 0; m_s1[c] = 0; m_s2[c] = 0; m_cause[c] = 2'b00;
      end
    end else begin
      m_cyc++;
      thr = (tmi == 5'b10010) ? 1 : DEB_CNT;
      off = (tmi == 5'b10011) ? 16 : RETRY_CYC;
      for (int c = 0; c < NCH; c++) begin
        ns = m_st[c];
        case (m_st[c])
          M_OFF: if (enable_fault[c]) ns = M_RUN;
          M_RUN: begin
            if (current_limit[c]) bk = (m_bkt[c] + 1 > ILIM_MAX) ? ILIM_MAX : m_bkt[c] + 1;
            else                  bk = (m_bkt[c] == 0) ? 0 : m_bkt[c] - 1;
            sh = (m_deb[c] >= thr) || (tmi == 5'b10001);
            il = (bk >= ILIM_MAX);
            if (sh || il) begin
              m_cause[c] = m_cause[c] | {il, sh};
              if (hiccup_en && (MAX_RETRY == 0 || m_rty[c] < MAX_RETRY)) begin
                ns = M_HIC; m_rty[c]++; m_hstart[c] = m_cyc;
              end else begin
                ns = M_LAT;
              end
              m_deb[c] = 0; m_bkt[c] = 0;
            end else begin
              m_deb[c] = m_s2[c] ? ((m_deb[c] < DEB_CNT) ? m_deb[c] + 1 : m_deb[c]) : 0;
              m_bkt[c] = bk;
            end
          end
          M_HIC: if (m_cyc - m_hstart[c] >= off) begin
            ns = M_RUN; m_deb[c] = 0; m_bkt[c] = 0;
          end
          M_LAT: if (clear_fault) ns = M_OFF;
          default: ns = M_OFF;
        endcase
        if (!enable_fault[c]) ns = M_OFF;
        if (ns == M_OFF) begin
          m_rty[c] = 0; m_cause[c] = 2'b00; m_deb[c] = 0; m_bkt[c] = 0;
        end
        m_st[c] = ns;
        m_s2[c] = m_s1[c];
        m_s1[c] = detect[c];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [3:0] e_en, e_ok, e_fs;
    logic [7:0] e_c;
    for (int c = 0; c < NCH; c++) begin
      e_en[c]       = (m_st[c] == M_RUN);
      e_ok[c]       = (m_st[c] == M_RUN) && !m_s2[c];
      e_fs[c]       = (m_st[c] == M_HIC) || (m_st[c] == M_LAT);
      e_c[2*c +: 2] = m_cause[c];
    end
    chk("enable", 32'(enable), 32'(e_en));
    chk("ok_fault", 32'(ok_fault), 32'(e_ok));
    chk("fault_short", 32'(fault_short), 32'(e_fs));
    chk("fault_cause", 32'(fault_cause), 32'(e_c));
    chk("fault_any", 32'(fault_any), 32'(|e_fs));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check_model();
    end
  endtask

  task automatic clean();
    detect = '0; current_limit = '0; clear_fault = 1'b0; tmi = '0;
    enable_fault = '0;
    step(3);
    enable_fault = 4'hF;
    step(1);
  endtask

  int  rises, cur;
  int  lens [4];
  bit  prev, now_b;

  initial begin
    // Reset
    step(3);
    chk("rst_enable", 32'(enable), 32'(0));
    chk("rst_fault_short", 32'(fault_short), 32'(0));
    chk("rst_fault_cause", 32'(fault_cause), 32'(0));
    enable_fault = 4'hF;
    rst_n = 1'b1;
    step(1);
    chk("run_enable", 32'(enable), 32'hF);
    chk("run_ok", 32'(ok_fault), 32'hF);

    // Short on channel 1, latch mode
    detect[1] = 1'b1;
    step(DEB_CNT + 2);
    chk("p1_before_trip", 32'(fault_short), 32'(0));
    step(1);
    chk("p1_fault_short", 32'(fault_short), 32'b0010);
    chk("p1_cause1", 32'(fault_cause[3:2]), 32'b01);
    chk("p1_enable", 32'(enable), 32'b1101);
    chk("p1_fault_any", 32'(fault_any), 32'(1));

    // Glitchy detect on channel 0 never reaches the debounce count
    clean();
    hiccup_en = 1'b0;
    detect[0] = 1'b1; step(7);
    chk("p2_ok0_low", 32'(ok_fault[0]), 32'(0));
    detect[0] = 1'b0; step(1);
    detect[0] = 1'b1; step(7);
    detect[0] = 1'b0; step(4);
    chk("p2_no_trip", 32'(fault_short), 32'(0));
    chk("p2_ok0_back", 32'(ok_fault[0]), 32'(1));

    // Hiccup retries on channel 2, then latch
    clean();
    hiccup_en = 1'b1;
    detect[2] = 1'b1;
    prev = 1'b0; rises = 0; cur = 0; lens = '{0, 0, 0, 0};
    for (int i = 0; i < 1700; i++) begin
      step(1);
      now_b = fault_short[2];
      if (now_b) begin
        if (!prev) rises++;
        cur++;
      end else if (prev) begin
        if (rises >= 1 && rises <= 4) lens[rises-1] = cur;
        cur = 0;
      end
      prev = now_b;
    end
    chk("p3_trip_count", 32'(rises), 32'(4));
    chk("p3_window0", 32'(lens[0]), 32'(RETRY_CYC));
    chk("p3_window1", 32'(lens[1]), 32'(RETRY_CYC));
    chk("p3_window2", 32'(lens[2]), 32'(RETRY_CYC));
    chk("p3_latched", 32'(fault_short), 32'b0100);
    hiccup_en = 1'b0; step(3);
    hiccup_en = 1'b1; step(3);
    chk("p3_hiccup_en_no_release", 32'(fault_short[2]), 32'(1));
    clear_fault = 1'b1; step(1);
    clear_fault = 1'b0;
    chk("p3_clear_off", 32'({enable[2], fault_short[2]}), 32'b00);
    step(1);
    chk("p3_rerun", 32'(enable[2]), 32'(1));
    step(DEB_CNT + 1);
    chk("p3_retrip", 32'(fault_short[2]), 32'(1));
    step(RETRY_CYC);
    chk("p3_retry_cleared", 32'(enable[2]), 32'(1));

    // Current-limit bucket on channel 3
    clean();
    hiccup_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      current_limit[3] = (i % 4) != 3;
      step(1);
    end
    chk("p4_ilim_trip", 32'(fault_short[3]), 32'(1));
    chk("p4_ilim_cause", 32'(fault_cause[7:6]), 32'b10);
    clean();
    for (int i = 0; i < 200; i++) begin
      current_limit[3] = (i % 2) == 0;
      step(1);
    end
    chk("p4_no_trip", 32'(fault_short), 32'(0));

    // Simultaneous short and ilimit trip on channel 0
    clean();
    hiccup_en = 1'b1;
    current_limit[0] = 1'b1;
    step(21);
    detect[0] = 1'b1;
    step(10);
    chk("p5_before_trip", 32'(fault_short[0]), 32'(0));
    step(1);
    chk("p5_both_trip", 32'(fault_short[0]), 32'(1));
    chk("p5_both_cause", 32'(fault_cause[1:0]), 32'b11);
    current_limit = '0;
    enable_fault[0] = 1'b0; step(1);
    enable_fault[0] = 1'b1; step(1);
    step(DEB_CNT);
    chk("p5_still_run", 32'(enable[0]), 32'(1));
    enable_fault[0] = 1'b0; step(1);
    chk("p5_off_wins", 32'({enable[0], fault_short[0], fault_cause[1:0]}), 32'(0));

    // Test modes and reset during hiccup
    clean();
    hiccup_en = 1'b1;
    tmi = 5'b10001; step(1);
    chk("p6_force", 32'(fault_short), 32'hF);
    chk("p6_force_cause", 32'(fault_cause), 32'h55);
    tmi = 5'b10011; step(15);
    chk("p6_fast_hold", 32'(fault_short), 32'hF);
    step(1);
    chk("p6_fast_done", 32'({enable, fault_short}), 32'hF0);
    tmi = 5'b10001; step(1);
    tmi = 5'b10011; step(5);
    #2 rst_n = 1'b0;
    #1;
    chk("p6_rst_async", 32'({enable, ok_fault, fault_short, fault_cause, fault_any}), 32'(0));
    check_model();
    enable_fault = '0; tmi = '0;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("p6_off_after_rst", 32'(enable), 32'(0));
    enable_fault = 4'hF; step(1);
    chk("p6_run_after_rst", 32'(enable), 32'hF);

    // Randomized soak against the model
    hiccup_en = 1'b1;
    tmi = 5'b10011;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) detect = 4'($urandom);
      for (int c = 0; c < NCH; c++) current_limit[c] = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 63) == 0) enable_fault[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 31) == 0) enable_fault = 4'hF;
      clear_fault = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 255) == 0) hiccup_en = ~hiccup_en;
      if ($urandom_range(0, 127) == 0) begin
        case ($urandom_range(0, 5))
          0:       tmi = 5'b00000;
          1:       tmi = 5'b10010;
          2:       tmi = 5'b00101;
          3:       tmi = 5'b10001;
          default: tmi = 5'b10011;
        endcase
      end else if (tmi == 5'b10001) begin
        tmi = 5'b10011;
      end
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
